// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Stage indices, FSM states and the hold/bubble bundle used by the datapath.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STG    = 32'd5;
  localparam int unsigned STG_IF     = 32'd0;
  localparam int unsigned STG_ID     = 32'd1;
  localparam int unsigned STG_EX     = 32'd2;
  localparam int unsigned STG_MEM    = 32'd3;
  localparam int unsigned STG_WB     = 32'd4;
  localparam int unsigned REG_ADDR_W = 32'd5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MCYC  = 2'd1,
    RPEND = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [NUM_STG-1:0] hold;
    logic [NUM_STG-1:0] bubble;
  } pipe_ctrl_t;

  // Mask with every stage from IF up to and including 'top' set.
  function automatic logic [NUM_STG-1:0] stages_upto(input int unsigned top);
    logic [NUM_STG-1:0] m;
    m = '0;
    for (int unsigned i = 32'd0; i < NUM_STG; i++) begin
      if (i <= top) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register
// an in-flight EX load has not yet produced.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  output logic                  load_use
);

  logic rd_live_s;
  logic src_hit_s;

  // x0 never carries a dependency, so a load into it cannot stall ID.
  assign rd_live_s = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid;
  assign src_hit_s = (id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd));
  assign load_use  = rd_live_s & src_hit_s;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and stall controller: per-stage hold/bubble, PC redirect,
// multicycle EX sequencing and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32'd64,
  parameter int unsigned LAT_W = 32'd6,
  parameter int unsigned CNT_W = 32'd32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_use1,
  input  logic                id_use2,
  input  logic                ex_valid,
  input  logic [4:0]          ex_rd,
  input  logic                ex_is_load,
  input  logic                ex_redirect,
  input  logic [XLEN-1:0]     ex_target,
  input  logic                mcyc_start,
  input  logic [LAT_W-1:0]    mcyc_lat,
  input  logic                ibus_busy,
  input  logic                ibus_done,
  input  logic                dbus_busy,
  output logic [4:0]          hold,
  output logic [4:0]          bubble,
  output logic [XLEN-1:0]     pc_in,
  output logic                pc_in_en,
  output logic                mcyc_busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e      state_r, state_s;
  logic [LAT_W-1:0] mcyc_cnt_r, mcyc_cnt_s;
  logic [XLEN-1:0]  tgt_r, tgt_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  pipe_ctrl_t       ctrl_s;
  logic             pc_in_en_s;
  logic [XLEN-1:0]  pc_in_s;
  logic             mcyc_busy_s;
  logic             redirect_s;
  logic             redirect_park_s;
  logic             load_use_s;

  pipe_ctrl_hazard_detect u_hazard (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use1    (id_use1),
    .id_use2    (id_use2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use_s)
  );

  // In RPEND the ID/EX slots are bubbled, so any redirect seen there is stale.
  assign redirect_s = ex_redirect & ex_valid & (state_r == RUN);

  // Priority-ordered hazard resolution and FSM next-state.
  always_comb begin
    ctrl_s          = '0;
    pc_in_en_s      = 1'b0;
    pc_in_s         = '0;
    state_s         = state_r;
    mcyc_cnt_s      = mcyc_cnt_r;
    tgt_s           = tgt_r;
    redirect_park_s = 1'b0;
    mcyc_busy_s     = (state_r == MCYC);

    // A held EX never redirects, so the branch is acted on exactly once.
    if (dbus_busy) begin
      ctrl_s.hold           = stages_upto(STG_MEM);
      ctrl_s.bubble[STG_WB] = 1'b1;
    end else if (mcyc_busy_s) begin
      ctrl_s.hold            = stages_upto(STG_EX);
      ctrl_s.bubble[STG_MEM] = 1'b1;
    end else if (redirect_s) begin
      ctrl_s.bubble[STG_ID:STG_IF] = 2'b11;
      if (!ibus_busy) begin
        pc_in_en_s = 1'b1;
        pc_in_s    = ex_target;
      end else begin
        redirect_park_s = 1'b1;
        tgt_s           = ex_target;
      end
    end else if (load_use_s) begin
      ctrl_s.hold           = stages_upto(STG_ID);
      ctrl_s.bubble[STG_EX] = 1'b1;
    end else if (ibus_busy) begin
      ctrl_s.bubble[STG_IF] = 1'b1;
    end else begin
      ctrl_s.bubble[STG_IF] = 1'b0;
    end

    case (state_r)
      RUN: begin
        if (mcyc_start && !dbus_busy) begin
          state_s    = MCYC;
          mcyc_cnt_s = mcyc_lat;
        end else if (redirect_park_s) begin
          state_s = RPEND;
        end else begin
          state_s = RUN;
        end
      end
      MCYC: begin
        if (dbus_busy) begin
          mcyc_cnt_s = mcyc_cnt_r;
        end else if (mcyc_cnt_r <= LAT_ONE) begin
          state_s    = RUN;
          mcyc_cnt_s = '0;
        end else begin
          mcyc_cnt_s = mcyc_cnt_r - LAT_ONE;
        end
      end
      RPEND: begin
        ctrl_s.bubble[STG_ID:STG_IF] = 2'b11;
        // The returning fetch is for the wrong path: drop it and redirect.
        if (ibus_done) begin
          pc_in_en_s = 1'b1;
          pc_in_s    = tgt_r;
          state_s    = RUN;
        end else begin
          state_s = RPEND;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase

    ctrl_s.bubble = ctrl_s.bubble & ~ctrl_s.hold;

    if (rst) begin
      ctrl_s      = '0;
      pc_in_en_s  = 1'b0;
      pc_in_s     = '0;
      mcyc_busy_s = 1'b0;
    end else begin
      mcyc_busy_s = mcyc_busy_s;
    end
  end

  // State, multicycle count, parked target and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      mcyc_cnt_r  <= '0;
      tgt_r       <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      mcyc_cnt_r <= mcyc_cnt_s;
      tgt_r      <= tgt_s;
      if (|ctrl_s.hold) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (pc_in_en_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign hold      = ctrl_s.hold;
  assign bubble    = ctrl_s.bubble;
  assign pc_in     = pc_in_s;
  assign pc_in_en  = pc_in_en_s;
  assign mcyc_busy = mcyc_busy_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: each step queues the expected
// control outputs and checks them (plus the counters) on the falling edge.
module tb_pipe_ctrl;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned LAT_W = 6;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid, id_use1, id_use2;
  logic [4:0]       id_rs1, id_rs2;
  logic             ex_valid, ex_is_load, ex_redirect;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_target;
  logic             mcyc_start;
  logic [LAT_W-1:0] mcyc_lat;
  logic             ibus_busy, ibus_done, dbus_busy;
  logic [4:0]       hold, bubble;
  logic [XLEN-1:0]  pc_in;
  logic             pc_in_en, mcyc_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string       tag;
    logic [4:0]  h;
    logic [4:0]  b;
    logic        en;
    logic        mb;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  pipe_ctrl #(.XLEN(XLEN), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mcyc_start(mcyc_start), .mcyc_lat(mcyc_lat),
    .ibus_busy(ibus_busy), .ibus_done(ibus_done), .dbus_busy(dbus_busy),
    .hold(hold), .bubble(bubble), .pc_in(pc_in), .pc_in_en(pc_in_en),
    .mcyc_busy(mcyc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_in();
    id_valid = 1'b0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    ex_rd = 5'd0; ex_target = 64'h0;
    mcyc_start = 1'b0; mcyc_lat = 6'd0;
    ibus_busy = 1'b0; ibus_done = 1'b0; dbus_busy = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] h, input logic [4:0] b,
                            input logic en, input logic mb, input logic [63:0] pc);
    exp_t e;
    e.tag = tag; e.h = h; e.b = b; e.en = en; e.mb = mb; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [75:0] obs;
    logic [75:0] req;
    e   = sb.pop_front();
    obs = {hold, bubble, pc_in_en, mcyc_busy, pc_in};
    req = {e.h, e.b, e.en, e.mb, e.pc};
    tests++;
    assert (obs === req) else begin
      failed++;
      $error("FAIL %s: got hold=%b bubble=%b en=%b busy=%b pc=%h, expected hold=%b bubble=%b en=%b busy=%b pc=%h",
             e.tag, hold, bubble, pc_in_en, mcyc_busy, pc_in, e.h, e.b, e.en, e.mb, e.pc);
    end
    tests++;
    assert ({stall_cnt, flush_cnt} === {m_stall, m_flush}) else begin
      failed++;
      $error("FAIL %s_cnt: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
             e.tag, stall_cnt, flush_cnt, m_stall, m_flush);
    end
    if (!rst) begin
      if (|e.h) m_stall++;
      if (e.en) m_flush++;
    end
  endtask

  task automatic step(input string tag, input logic [4:0] h, input logic [4:0] b,
                      input logic en, input logic mb, input logic [63:0] pc);
    expect_out(tag, h, b, en, mb, pc);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset gates the outputs even with a redirect and a load-use presented.
    clear_in();
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_0040;
    expect_out("reset", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    check_now();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_in();
    step("idle", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Load-use on rs1, x0 destination, rs2 hit, rs2 unused.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    id_valid = 1'b1; id_use1 = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
    step("ldu_rs1", 5'b00011, 5'b00100, 1'b0, 1'b0, 64'h0);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    step("ldu_x0", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use2 = 1'b1;
    step("ldu_rs2", 5'b00011, 5'b00100, 1'b0, 1'b0, 64'h0);
    id_use2 = 1'b0;
    step("ldu_nouse", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Redirect with idle fetch.
    clear_in();
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_0040;
    step("redir_idle", 5'b00000, 5'b00011, 1'b1, 1'b0, 64'h8000_0040);
    clear_in();
    step("after_redir", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Redirect while a fetch is in flight; a stale redirect in RPEND is ignored.
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_1000; ibus_busy = 1'b1;
    step("rp_enter", 5'b00000, 5'b00011, 1'b0, 1'b0, 64'h0);
    ex_target = 64'hdead_beef;
    step("rp_wait1", 5'b00000, 5'b00011, 1'b0, 1'b0, 64'h0);
    clear_in(); ibus_busy = 1'b1;
    step("rp_wait2", 5'b00000, 5'b00011, 1'b0, 1'b0, 64'h0);
    clear_in(); ibus_done = 1'b1;
    step("rp_done", 5'b00000, 5'b00011, 1'b1, 1'b0, 64'h8000_1000);
    clear_in();
    step("rp_exit", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Multicycle latency 4.
    ex_valid = 1'b1; mcyc_start = 1'b1; mcyc_lat = 6'd4;
    step("mc_start", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    clear_in();
    for (int i = 0; i < 4; i++) step("mc4_busy", 5'b00111, 5'b01000, 1'b0, 1'b1, 64'h0);
    step("mc4_done", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Multicycle latency 4 with two dbus wait cycles inside.
    mcyc_start = 1'b1; mcyc_lat = 6'd4;
    step("mcd_start", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    clear_in();
    step("mcd_1", 5'b00111, 5'b01000, 1'b0, 1'b1, 64'h0);
    dbus_busy = 1'b1;
    step("mcd_db1", 5'b01111, 5'b10000, 1'b0, 1'b1, 64'h0);
    step("mcd_db2", 5'b01111, 5'b10000, 1'b0, 1'b1, 64'h0);
    dbus_busy = 1'b0;
    for (int i = 0; i < 3; i++) step("mcd_tail", 5'b00111, 5'b01000, 1'b0, 1'b1, 64'h0);
    step("mcd_done", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Minimum latency: one busy cycle.
    mcyc_start = 1'b1; mcyc_lat = 6'd1;
    step("mc1_start", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    clear_in();
    step("mc1_busy", 5'b00111, 5'b01000, 1'b0, 1'b1, 64'h0);
    step("mc1_done", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // dbus wait outranks a redirect; redirect taken once dbus clears.
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_2000; dbus_busy = 1'b1;
    step("prio_db1", 5'b01111, 5'b10000, 1'b0, 1'b0, 64'h0);
    step("prio_db2", 5'b01111, 5'b10000, 1'b0, 1'b0, 64'h0);
    dbus_busy = 1'b0;
    step("prio_take", 5'b00000, 5'b00011, 1'b1, 1'b0, 64'h8000_2000);
    clear_in();
    step("prio_idle", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    // Asynchronous reset between edges while parked in RPEND.
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_3000; ibus_busy = 1'b1;
    step("rr_enter", 5'b00000, 5'b00011, 1'b0, 1'b0, 64'h0);
    clear_in(); ibus_busy = 1'b1;
    step("rr_wait", 5'b00000, 5'b00011, 1'b0, 1'b0, 64'h0);
    clear_in(); ibus_done = 1'b1;
    #2;
    rst = 1'b1;
    m_stall = 0; m_flush = 0;
    #1;
    expect_out("rst_async", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    check_now();
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst_done", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);
    clear_in();
    step("post_rst_idle", 5'b00000, 5'b00000, 1'b0, 1'b0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
